// File: rtl/axi_fetch_resp_unpacker_if.sv
// Bundle of the descriptor, wide beat and narrow word streams of the fetch response unpacker.
// The slave modport is the unpacker's view; master is the surrounding fabric's view.
interface axi_fetch_resp_unpacker_if #(
    parameter int IN_WIDTH       = 512,
    parameter int OUT_WIDTH      = 32,
    parameter int MAX_BYTE_COUNT = 1000000000
);
    localparam int CW = $clog2(MAX_BYTE_COUNT);

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [CW-1:0]          cfg_byte_count;

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [IN_WIDTH-1:0]    in_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH-1:0]   out_data;
    logic [OUT_WIDTH/8-1:0] out_strb;
    logic                   out_last;

    logic                   done;
    logic                   err_len;

    modport slave (
        input  cfg_valid, cfg_byte_count,
        input  in_valid, in_last, in_data,
        input  out_ready,
        output cfg_ready, in_ready,
        output out_valid, out_data, out_strb, out_last,
        output done, err_len
    );

    modport master (
        output cfg_valid, cfg_byte_count,
        output in_valid, in_last, in_data,
        output out_ready,
        input  cfg_ready, in_ready,
        input  out_valid, out_data, out_strb, out_last,
        input  done, err_len
    );
endinterface

// File: rtl/axi_fetch_resp_unpacker.sv
// Serialises wide fetch response beats into narrow LSB-first words, trimmed to a per-request byte count.
// Defining AXI_UNPACK_PREFETCH_EN adds a second beat buffer so consecutive beats stream without a bubble.
module axi_fetch_resp_unpacker #(
    parameter int IN_WIDTH       = 512,
    parameter int OUT_WIDTH      = 32,
    parameter int MAX_BYTE_COUNT = 1000000000
) (
    input  logic                     core_clk,
    input  logic                     resetn,
    axi_fetch_resp_unpacker_if.slave bus
);
    localparam int CW  = $clog2(MAX_BYTE_COUNT);
    localparam int WPB = IN_WIDTH / OUT_WIDTH;
    localparam int BPW = OUT_WIDTH / 8;
    localparam int BPB = IN_WIDTH / 8;
    localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    typedef logic [WPB-1:0][OUT_WIDTH-1:0] beat_t;

    state_t         state;
    state_t         next_state;
    beat_t          cur_beat;
    logic [CW-1:0]  words_left;
    logic [CW-1:0]  beats_left;
    logic [IW-1:0]  word_idx;
    logic [BPW-1:0] tail_strb;
    logic           done_r;
    logic           err_r;

    logic           cfg_ready;
    logic           in_ready;
    logic           out_valid;
    logic           cfg_fire;
    logic           beat_fire;
    logic           word_fire;
    logic           last_word;
    logic           beat_end;

    logic [CW-1:0]  word_rem;
    logic [CW-1:0]  beat_rem;
    logic [CW-1:0]  words_calc;
    logic [CW-1:0]  beats_calc;
    logic [BPW-1:0] tail_calc;

`ifdef AXI_UNPACK_PREFETCH_EN
    beat_t          next_beat;
    logic           next_valid;
`endif

    // Request geometry: ceil-divided word and beat counts plus the byte strobe of the final word.
    always_comb begin
        word_rem   = bus.cfg_byte_count % CW'(BPW);
        beat_rem   = bus.cfg_byte_count % CW'(BPB);
        words_calc = bus.cfg_byte_count / CW'(BPW) + CW'(word_rem != '0);
        beats_calc = bus.cfg_byte_count / CW'(BPB) + CW'(beat_rem != '0);
        tail_calc  = '0;
        for (int i = 0; i < BPW; i++) begin
            tail_calc[i] = (word_rem == '0) || (CW'(i) < word_rem);
        end
    end

    assign last_word = (words_left == CW'(1));
    assign beat_end  = (word_idx == IW'(WPB - 1));

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A final-word handshake always returns to IDLE, even mid-beat, so trailing words are never shown.
    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (bus.cfg_valid && (bus.cfg_byte_count != '0)) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                in_ready = (beats_left != '0);
                if (bus.in_valid && in_ready) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
`ifdef AXI_UNPACK_PREFETCH_EN
                in_ready = !next_valid && (beats_left != '0);
`endif
                if (bus.out_ready) begin
                    if (last_word) begin
                        next_state = IDLE;
                    end else if (beat_end) begin
`ifdef AXI_UNPACK_PREFETCH_EN
                        if (!next_valid && !(bus.in_valid && in_ready)) begin
                            next_state = LOAD;
                        end
`else
                        next_state = LOAD;
`endif
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign cfg_fire  = cfg_ready && bus.cfg_valid;
    assign beat_fire = in_ready && bus.in_valid;
    assign word_fire = out_valid && bus.out_ready;

    // Counters, beat buffer(s) and status; a length error never stops the request, the byte count rules.
    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            cur_beat   <= '0;
            words_left <= '0;
            beats_left <= '0;
            word_idx   <= '0;
            tail_strb  <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
`ifdef AXI_UNPACK_PREFETCH_EN
            next_beat  <= '0;
            next_valid <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;

            if (cfg_fire) begin
                words_left <= words_calc;
                beats_left <= beats_calc;
                tail_strb  <= tail_calc;
                word_idx   <= '0;
                err_r      <= 1'b0;
                if (bus.cfg_byte_count == '0) begin
                    done_r <= 1'b1;
                end
            end

            if (beat_fire) begin
                beats_left <= beats_left - CW'(1);
                if (bus.in_last != (beats_left == CW'(1))) begin
                    err_r <= 1'b1;
                end
`ifdef AXI_UNPACK_PREFETCH_EN
                if ((state == LOAD) || (word_fire && beat_end)) begin
                    cur_beat <= bus.in_data;
                end else begin
                    next_beat  <= bus.in_data;
                    next_valid <= 1'b1;
                end
`else
                cur_beat <= bus.in_data;
`endif
            end

            if (word_fire) begin
                words_left <= words_left - CW'(1);
                word_idx   <= beat_end ? '0 : word_idx + IW'(1);
                if (last_word) begin
                    done_r <= 1'b1;
                end
`ifdef AXI_UNPACK_PREFETCH_EN
                if (beat_end && next_valid) begin
                    cur_beat   <= next_beat;
                    next_valid <= 1'b0;
                end
`endif
            end
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? cur_beat[word_idx] : '0;
    assign bus.out_strb  = out_valid ? (last_word ? tail_strb : '1) : '0;
    assign bus.out_last  = out_valid && last_word;
    assign bus.done      = done_r;
    assign bus.err_len   = err_r;
endmodule

// File: tb/tb_axi_fetch_resp_unpacker.sv
// Directed bench for axi_fetch_resp_unpacker: byte-counted requests, tail trimming, stalls, length errors, reset.
// Beat b carries byte value (64*b + i) at byte lane i, so word n is expected to be {4n+3, 4n+2, 4n+1, 4n}.
module tb_axi_fetch_resp_unpacker;
    localparam int IN_WIDTH       = 512;
    localparam int OUT_WIDTH      = 32;
    localparam int MAX_BYTE_COUNT = 1000000000;
    localparam int CW             = $clog2(MAX_BYTE_COUNT);
    localparam int BEATS          = 4;

    logic core_clk = 1'b0;
    logic resetn;

    always #5 core_clk = ~core_clk;

    axi_fetch_resp_unpacker_if #(
        .IN_WIDTH(IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .MAX_BYTE_COUNT(MAX_BYTE_COUNT)
    ) bus ();

    axi_fetch_resp_unpacker #(
        .IN_WIDTH(IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .MAX_BYTE_COUNT(MAX_BYTE_COUNT)
    ) dut (
        .core_clk(core_clk),
        .resetn(resetn),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [IN_WIDTH-1:0] beats [BEATS];
    int words_seen;
    int beats_taken;
    int done_cyc;
    int first_v;
    int last_v;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    function automatic logic [31:0] expWord(input int n);
        return {8'(4*n + 3), 8'(4*n + 2), 8'(4*n + 1), 8'(4*n)};
    endfunction

    function automatic logic [3:0] tailStrb(input int count);
        case (count % 4)
            0:       return 4'hF;
            1:       return 4'h1;
            2:       return 4'h3;
            default: return 4'h7;
        endcase
    endfunction

    // One request: beats offered back to back, every presented word checked against the byte model.
    task automatic applyStimulus(input int count, input int last_at, input bit stall, input bit exp_err);
        int exp_words;
        int exp_beats;
        int n;
        int bi;
        int cyc;
        exp_words = (count + 3) / 4;
        exp_beats = (count + 63) / 64;
        n         = 0;
        bi        = 0;
        cyc       = 0;
        done_cyc  = -1;
        first_v   = -1;
        last_v    = -1;

        checkOutput("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
        bus.cfg_byte_count = CW'(count);
        bus.cfg_valid      = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;

        while ((cyc < 400) && (done_cyc < 0)) begin
            bus.in_valid  = (bi < BEATS);
            bus.in_data   = beats[bi % BEATS];
            bus.in_last   = (bi == last_at);
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.done) begin
                done_cyc = cyc;
            end
            if (bus.out_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                end
                last_v = cyc;
                checkOutput("word_data", 64'(bus.out_data), 64'(expWord(n)));
                checkOutput("word_strb", 64'(bus.out_strb),
                            64'((n == exp_words - 1) ? tailStrb(count) : 4'hF));
                checkOutput("word_last", 64'(bus.out_last), 64'(n == exp_words - 1));
                if (bus.out_ready) begin
                    n++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                bi++;
            end
            tick();
            cyc++;
        end

        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        words_seen    = n;
        beats_taken   = bi;

        checkOutput("done_seen", 64'(done_cyc >= 0), 64'd1);
        checkOutput("word_count", 64'(n), 64'(exp_words));
        checkOutput("beat_count", 64'(bi), 64'(exp_beats));
        checkOutput("err_len", 64'(bus.err_len), 64'(exp_err));
        tick();
        checkOutput("done_pulse_width", 64'(bus.done), 64'd0);
        checkOutput("cfg_ready_after", 64'(bus.cfg_ready), 64'd1);
    endtask

    initial begin
        for (int b = 0; b < BEATS; b++) begin
            for (int i = 0; i < 64; i++) begin
                beats[b][i*8 +: 8] = 8'(b*64 + i);
            end
        end

        resetn             = 1'b0;
        bus.cfg_valid      = 1'b0;
        bus.cfg_byte_count = '0;
        bus.in_valid       = 1'b0;
        bus.in_last        = 1'b0;
        bus.in_data        = '0;
        bus.out_ready      = 1'b0;

        #3;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
        checkOutput("rst_out_strb", 64'(bus.out_strb), 64'd0);
        checkOutput("rst_out_last", 64'(bus.out_last), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_err_len", 64'(bus.err_len), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("cfg_ready_out_of_rst", 64'(bus.cfg_ready), 64'd1);

        $display("[TB] single full beat, 64 bytes");
        applyStimulus(64, 0, 1'b0, 1'b0);
        checkOutput("first_word_latency", 64'(first_v), 64'd1);

        $display("[TB] 70 bytes over two beats");
        applyStimulus(70, 1, 1'b0, 1'b0);

        $display("[TB] zero byte request");
        applyStimulus(0, -1, 1'b0, 1'b0);
        checkOutput("zero_done_cycle", 64'(done_cyc), 64'd0);

        $display("[TB] 128 bytes with random output stalls");
        applyStimulus(128, 1, 1'b1, 1'b0);

        $display("[TB] 128 bytes, output always ready");
        applyStimulus(128, 1, 1'b0, 1'b0);
`ifdef AXI_UNPACK_PREFETCH_EN
        checkOutput("valid_span", 64'(last_v - first_v + 1), 64'd32);
`else
        checkOutput("valid_span", 64'(last_v - first_v + 1), 64'd33);
`endif

        $display("[TB] early in_last on 128 bytes");
        applyStimulus(128, 0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("err_sticky", 64'(bus.err_len), 64'd1);
        applyStimulus(64, 0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a drain");
        bus.cfg_byte_count = CW'(64);
        bus.cfg_valid      = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = beats[0];
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("mid_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("mid_word5", 64'(bus.out_data), 64'(expWord(5)));
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("abort_out_data", 64'(bus.out_data), 64'd0);
        checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("post_rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("post_rst_done", 64'(bus.done), 64'd0);
        applyStimulus(64, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
